// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requests, push to IFQ.
// Ports: clk/rst, jmp_br_*, imem_*, ifq_*, stall_cnt. Macro: IFU_STALL_CNT_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jmp_br_valid,
    input  logic [DATA_WIDTH-1:0]     jmp_br_addr,
    output logic                      imem_rd_en,
    output logic [DATA_WIDTH-1:0]     imem_addr,
    input  logic                      imem_rd_valid,
    input  logic [DATA_WIDTH-1:0]     imem_rd_data,
    input  logic                      ifq_full,
    output logic                      ifq_push,
    output logic [2*DATA_WIDTH-1:0]   ifq_data,
    output logic                      ifq_flush,
    output logic [31:0]               stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DROP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  flush_q, flush_d;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;

    // Redirects are ignored during the post-reset IDLE cycle.
    assign redirect = jmp_br_valid && (state_q != S_IDLE);
    assign target   = {jmp_br_addr[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        flush_d = redirect;
        if (redirect) begin
            pc_d = target;
        end
        case (state_q)
            S_IDLE: state_d = S_REQ;
            // The request still goes out this cycle, so its response
            // must be swallowed in DROP.
            S_REQ: state_d = redirect ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rd_valid ? S_REQ : S_DROP;
                end else if (imem_rd_valid) begin
                    buf_d   = imem_rd_data;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!ifq_full) begin
                    pc_d    = pc_q + DATA_WIDTH'(4);
                    state_d = S_REQ;
                end
            end
            // A response arriving together with a further redirect is the
            // one being dropped; leaving DROP then avoids waiting forever.
            S_DROP: begin
                if (imem_rd_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= DATA_WIDTH'(RESET_PC);
            buf_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            flush_q <= flush_d;
        end
    end

    assign imem_rd_en = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign ifq_push   = (state_q == S_PUSH) && !ifq_full && !jmp_br_valid;
    assign ifq_data   = (state_q == S_PUSH) ? {pc_q, buf_q} : '0;
    assign ifq_flush  = flush_q;

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_PUSH) && ifq_full && !jmp_br_valid &&
            (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
